fpjh_send: RTL and testbench

Fragmenting sender of the fragment/aggregate (fpjh) link. It accepts whole packets on a 32-bit AXI-Stream input, each with a declared byte length. It buffers each packet completely, then re-emits it as one or more fragments. Each fragment is one header word followed by at most `FRAG_BYTES` of payload. The peer block `fpjh_rece` strips the headers and reassembles the packets.

---
 rtl/fpjh_pkg.sv | 36 +++
 rtl/fpjh_sync_fifo.sv | 45 ++++
 rtl/fpjh_send.sv | 191 +++++++++++++++++++
 tb/tb_fpjh_send.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpjh_pkg.sv
// Shared definitions for the fpjh fragment/aggregate link. This package is used by
// both the sender and the receiver: it holds the header layout, the FSM states and the byte-count helper.
package fpjh_pkg;

  localparam logic [7:0] MAGIC = 8'hA5;

  localparam int HDR_MAGIC_LSB = 24;
  localparam int HDR_FIRST_BIT = 23;
  localparam int HDR_LAST_BIT  = 22;
  localparam int HDR_ERR_BIT   = 21;
  localparam int HDR_SEQ_LSB   = 16;
  localparam int HDR_IDX_LSB   = 12;
  localparam int HDR_BYTES_LSB = 0;

  typedef struct packed {
    logic [7:0]  magic;
    logic        first;
    logic        last;
    logic        len_err;
    logic [4:0]  seq;
    logic [3:0]  idx;
    logic [11:0] bytes;
  } hdr_t;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY
  } state_t;

  // Valid byte count of an MSB-first keep pattern.
  function automatic logic [2:0] keep_bytes(input logic [3:0] keep);
    keep_bytes = {2'b00, keep[3]} + {2'b00, keep[2]} + {2'b00, keep[1]} + {2'b00, keep[0]};
  endfunction

endpackage

// File: rtl/fpjh_sync_fifo.sv
// First-word fall-through synchronous FIFO. The read data always shows the oldest entry.
// It uses an extra pointer bit to tell full from empty.
module fpjh_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fpjh_send.sv
// Fragmenting sender. It stores each whole packet and then re-emits it as fragments.
// Each fragment is a header word followed by up to FRAG_BYTES of payload.
module fpjh_send
  import fpjh_pkg::*;
#(
  parameter int FRAG_BYTES = 256,
  parameter int DATA_DEPTH = 1024,
  parameter int LEN_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] i_length,
  input  logic [31:0] i_axis_tdata,
  input  logic [3:0]  i_axis_tkeep,
  input  logic        i_axis_tvalid,
  input  logic        i_axis_tlast,
  output logic        i_axis_tready,
  output logic [31:0] o_axis_tdata,
  output logic [3:0]  o_axis_tkeep,
  output logic        o_axis_tvalid,
  output logic        o_axis_tlast,
  input  logic        o_axis_tready
);

  localparam logic [11:0] FRAG12 = 12'(FRAG_BYTES);

  logic        ready_en;
  logic        in_fire;
  logic        first_beat;
  logic [11:0] len_q;
  logic [11:0] byte_cnt;
  logic [11:0] len_ref;
  logic [11:0] beat_total;

  logic        data_full, data_empty, data_rd_en;
  logic [36:0] data_rd;
  logic        len_full, len_empty, len_rd_en, len_wr_en;
  logic [12:0] len_rd, len_wr_data;

  state_t      state;
  logic [4:0]  seq;
  logic [3:0]  frag_idx;
  logic [11:0] rem_bytes;
  logic [10:0] frag_words;
  logic        len_err_q;

  logic [11:0] hdr_rem;
  logic [11:0] hdr_bytes;
  logic        hdr_last;
  logic [10:0] hdr_words;
  hdr_t        hdr;

  assign i_axis_tready = ready_en && !data_full && !len_full;
  assign in_fire       = i_axis_tvalid && i_axis_tready;

  // The byte count comes from the beats themselves, and the declared length is only compared against it.
  assign len_ref     = first_beat ? i_length : len_q;
  assign beat_total  = (first_beat ? 12'd0 : byte_cnt) +
                       (i_axis_tlast ? {9'd0, keep_bytes(i_axis_tkeep)} : 12'd4);
  assign len_wr_en   = in_fire && i_axis_tlast;
  assign len_wr_data = {beat_total, (len_ref != beat_total)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en   <= 1'b0;
      first_beat <= 1'b1;
      len_q      <= '0;
      byte_cnt   <= '0;
    end else begin
      ready_en <= 1'b1;
      if (in_fire) begin
        if (first_beat) len_q <= i_length;
        if (i_axis_tlast) begin
          first_beat <= 1'b1;
          byte_cnt   <= '0;
        end else begin
          first_beat <= 1'b0;
          byte_cnt   <= beat_total;
        end
      end
    end
  end

  fpjh_sync_fifo #(.WIDTH(37), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_fire),
    .wr_data ({i_axis_tlast, i_axis_tkeep, i_axis_tdata}),
    .rd_en   (data_rd_en),
    .rd_data (data_rd),
    .full    (data_full),
    .empty   (data_empty)
  );

  fpjh_sync_fifo #(.WIDTH(13), .DEPTH(LEN_DEPTH)) u_len_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (len_wr_en),
    .wr_data (len_wr_data),
    .rd_en   (len_rd_en),
    .rd_data (len_rd),
    .full    (len_full),
    .empty   (len_empty)
  );

  // Next header. It is built from a fresh length entry in IDLE, or from the leftover bytes after a fragment.
  assign hdr_rem   = (state == IDLE) ? len_rd[12:1] : rem_bytes;
  assign hdr_last  = (hdr_rem <= FRAG12);
  assign hdr_bytes = hdr_last ? hdr_rem : FRAG12;
  assign hdr_words = 11'(({1'b0, hdr_bytes} + 13'd3) >> 2);

  always_comb begin
    hdr         = '0;
    hdr.magic   = MAGIC;
    hdr.first   = (state == IDLE);
    hdr.last    = hdr_last;
    hdr.len_err = (state == IDLE) ? len_rd[0] : len_err_q;
    hdr.seq     = seq;
    hdr.idx     = (state == IDLE) ? 4'd0 : frag_idx + 4'd1;
    hdr.bytes   = hdr_bytes;
  end

  assign len_rd_en  = (state == IDLE) && !len_empty;
  assign data_rd_en = o_axis_tready && ((state == HDR) || ((state == PAY) && !o_axis_tlast));

  // The output registers change only on a handshake, so they hold steady while downstream stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      seq           <= '0;
      frag_idx      <= '0;
      rem_bytes     <= '0;
      frag_words    <= '0;
      len_err_q     <= 1'b0;
      o_axis_tdata  <= '0;
      o_axis_tkeep  <= '0;
      o_axis_tvalid <= 1'b0;
      o_axis_tlast  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!len_empty) begin
            o_axis_tdata  <= hdr;
            o_axis_tkeep  <= 4'hF;
            o_axis_tvalid <= 1'b1;
            o_axis_tlast  <= 1'b0;
            len_err_q     <= len_rd[0];
            frag_idx      <= hdr.idx;
            rem_bytes     <= hdr_rem - hdr_bytes;
            frag_words    <= hdr_words;
            state         <= HDR;
          end
        end
        HDR: begin
          if (o_axis_tready) begin
            o_axis_tdata <= data_rd[31:0];
            o_axis_tkeep <= data_rd[35:32];
            o_axis_tlast <= (frag_words == 11'd1) || data_rd[36];
            frag_words   <= frag_words - 11'd1;
            state        <= PAY;
          end
        end
        PAY: begin
          if (o_axis_tready) begin
            if (!o_axis_tlast) begin
              o_axis_tdata <= data_rd[31:0];
              o_axis_tkeep <= data_rd[35:32];
              o_axis_tlast <= (frag_words == 11'd1) || data_rd[36];
              frag_words   <= frag_words - 11'd1;
            end else if (rem_bytes != 12'd0) begin
              o_axis_tdata <= hdr;
              o_axis_tkeep <= 4'hF;
              o_axis_tlast <= 1'b0;
              frag_idx     <= hdr.idx;
              rem_bytes    <= hdr_rem - hdr_bytes;
              frag_words   <= hdr_words;
              state        <= HDR;
            end else begin
              o_axis_tvalid <= 1'b0;
              o_axis_tlast  <= 1'b0;
              seq           <= seq + 5'd1;
              state         <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpjh_send.sv
// Bench for fpjh_send. It runs two instances, with 256-byte and 32-byte fragments, from one input stream.
// Each output is checked against a packet-level fragmentation model.
module tb_fpjh_send;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  localparam int FRAGS [2] = '{256, 32};

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [11:0]      i_length = '0;
  logic [31:0]      i_tdata = '0;
  logic [3:0]       i_tkeep = '0;
  logic             i_tvalid = 1'b0;
  logic             i_tlast = 1'b0;
  logic [1:0]       i_ready;
  logic [1:0][31:0] o_data;
  logic [1:0][3:0]  o_keep;
  logic [1:0]       o_valid;
  logic [1:0]       o_last;
  logic             o_ready = 1'b1;

  int    tests = 0;
  int    fails = 0;
  int    seqm [2] = '{0, 0};
  beat_t expq [2][$];
  beat_t got  [2][$];
  logic  started = 1'b0;
  logic  bp_on = 1'b0;
  logic [1:0]  stall_prev = '0;
  logic [37:0] held [2];

  always #5 clk = ~clk;

  fpjh_send #(.FRAG_BYTES(256), .DATA_DEPTH(1024), .LEN_DEPTH(16)) u_dut256 (
    .clk(clk), .rst(rst), .i_length(i_length),
    .i_axis_tdata(i_tdata), .i_axis_tkeep(i_tkeep), .i_axis_tvalid(i_tvalid),
    .i_axis_tlast(i_tlast), .i_axis_tready(i_ready[0]),
    .o_axis_tdata(o_data[0]), .o_axis_tkeep(o_keep[0]), .o_axis_tvalid(o_valid[0]),
    .o_axis_tlast(o_last[0]), .o_axis_tready(o_ready)
  );

  fpjh_send #(.FRAG_BYTES(32), .DATA_DEPTH(1024), .LEN_DEPTH(16)) u_dut32 (
    .clk(clk), .rst(rst), .i_length(i_length),
    .i_axis_tdata(i_tdata), .i_axis_tkeep(i_tkeep), .i_axis_tvalid(i_tvalid),
    .i_axis_tlast(i_tlast), .i_axis_tready(i_ready[1]),
    .o_axis_tdata(o_data[1]), .o_axis_tkeep(o_keep[1]), .o_axis_tvalid(o_valid[1]),
    .o_axis_tlast(o_last[1]), .o_axis_tready(o_ready)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Model: this turns a whole packet into its fragment beats, using plain arithmetic on the byte count.
  task automatic modelPacket(input int n, input logic [3:0] last_keep, input int ilen, input logic [31:0] base);
    int bytes, rem, idx, w, fb, nw;
    logic err;
    beat_t b;
    bytes = 4 * (n - 1) + $countones(last_keep);
    err = (ilen != bytes);
    for (int d = 0; d < 2; d++) begin
      rem = bytes;
      idx = 0;
      w = 0;
      while (rem > 0) begin
        fb = (rem > FRAGS[d]) ? FRAGS[d] : rem;
        b.data = {8'hA5, (idx == 0), (rem <= FRAGS[d]), err, 5'(seqm[d]), 4'(idx), 12'(fb)};
        b.keep = 4'hF;
        b.last = 1'b0;
        expq[d].push_back(b);
        nw = (fb + 3) / 4;
        for (int j = 0; j < nw; j++) begin
          b.data = base + 32'(w);
          b.keep = (w == n - 1) ? last_keep : 4'hF;
          b.last = (j == nw - 1);
          expq[d].push_back(b);
          w++;
        end
        rem -= fb;
        idx++;
      end
      seqm[d] = (seqm[d] + 1) % 32;
    end
  endtask

  task automatic sendBeat(input logic [31:0] data, input logic [3:0] keep, input logic last, input logic [11:0] len);
    int waitc;
    logic acc;
    i_tdata  = data;
    i_tkeep  = keep;
    i_tlast  = last;
    i_length = len;
    i_tvalid = 1'b1;
    waitc = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = i_ready[0] & i_ready[1];
      @(posedge clk);
      #1;
      waitc++;
      if (!acc && waitc > 3000) begin
        tests++;
        fails++;
        $display("[TB] FAIL input_timeout: got tready=%b, expected 11", i_ready);
        break;
      end
    end
    i_tvalid = 1'b0;
  endtask

  task automatic applyStimulus(input int n, input logic [3:0] last_keep, input int ilen, input logic [31:0] base);
    modelPacket(n, last_keep, ilen, base);
    for (int i = 0; i < n; i++)
      sendBeat(base + 32'(i), (i == n - 1) ? last_keep : 4'hF, (i == n - 1),
               (i == 0) ? 12'(ilen) : ~12'(ilen));
  endtask

  task automatic waitDrain();
    int c;
    c = 0;
    while ((expq[0].size() != 0 || expq[1].size() != 0) && c < 20000) begin
      @(posedge clk);
      c++;
    end
    checkOutput("drain_pending", 64'(expq[0].size() + expq[1].size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    started = 1'b1;
  end

  // Compare process: every handshake is checked against the model, and any stall must hold all outputs.
  always @(negedge clk) begin
    beat_t e;
    beat_t b;
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        if (!rst) begin
          tests++;
          if (o_valid[d] || o_last[d] || o_data[d] != 0 || o_keep[d] != 0 || i_ready[d]) begin
            fails++;
            $display("[TB] FAIL reset_outputs_d%0d: got valid=%b data=%h keep=%h last=%b ready=%b, expected all 0",
                     d, o_valid[d], o_data[d], o_keep[d], o_last[d], i_ready[d]);
          end
          stall_prev[d] = 1'b0;
        end else begin
          if (stall_prev[d]) begin
            tests++;
            if ({o_valid[d], o_data[d], o_keep[d], o_last[d]} != held[d]) begin
              fails++;
              $display("[TB] FAIL hold_d%0d: got %h, expected %h", d,
                       {o_valid[d], o_data[d], o_keep[d], o_last[d]}, held[d]);
            end
          end
          if (o_valid[d] && o_ready) begin
            b = {o_data[d], o_keep[d], o_last[d]};
            tests++;
            if (expq[d].size() == 0) begin
              fails++;
              $display("[TB] FAIL spurious_beat_d%0d: got %h, expected no beat", d, b);
            end else begin
              e = expq[d].pop_front();
              if (b != e) begin
                fails++;
                $display("[TB] FAIL beat_d%0d: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                         d, b.data, b.keep, b.last, e.data, e.keep, e.last);
              end
            end
            got[d].push_back(b);
          end
          stall_prev[d] = o_valid[d] && !o_ready;
          held[d] = {o_valid[d], o_data[d], o_keep[d], o_last[d]};
        end
      end
    end
  end

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("ready_before_first_clock", 64'(i_ready), 64'd0);
    @(negedge clk);
    checkOutput("ready_after_release", 64'(i_ready), 64'd3);
    @(posedge clk);
    #1;

    // A 57-byte packet: one fragment at 256, and two fragments at 32.
    applyStimulus(15, 4'h8, 57, 32'h0100_0000);
    checkOutput("model_hdr256", 64'(expq[0][0].data), 64'hA5C0_0039);
    checkOutput("model_hdr32_2", 64'(expq[1][9].data), 64'hA540_1019);
    @(negedge clk);
    checkOutput("latency_cycle1", 64'(o_valid), 64'd0);
    @(negedge clk);
    checkOutput("latency_cycle2", 64'(o_valid), 64'd3);
    waitDrain();
    checkOutput("hdr256", 64'(got[0][0].data), 64'hA5C0_0039);
    checkOutput("last256", 64'(got[0][15]), 64'({32'h0100_000E, 4'h8, 1'b1}));
    checkOutput("hdr32_a", 64'(got[1][0].data), 64'hA580_0020);
    checkOutput("tlast32_w8", 64'(got[1][8].last), 64'd1);
    checkOutput("hdr32_b", 64'(got[1][9].data), 64'hA540_1019);
    checkOutput("last32", 64'({got[1][16].keep, got[1][16].last}), 64'h11);

    // The declared length disagrees with the beats, so the beat count wins and the error flag is set.
    applyStimulus(15, 4'h8, 60, 32'h0200_0000);
    waitDrain();
    checkOutput("len_err_hdr", 64'(got[0][16].data), 64'hA5E1_0039);

    // Fragment-size edges, sent back to back.
    applyStimulus(1, 4'hE, 3, 32'h0300_0000);
    applyStimulus(8, 4'hF, 32, 32'h0400_0000);
    applyStimulus(9, 4'h8, 33, 32'h0500_0000);
    applyStimulus(64, 4'hF, 256, 32'h0600_0000);
    applyStimulus(65, 4'hC, 258, 32'h0700_0000);
    waitDrain();

    // Random downstream backpressure.
    bp_on = 1'b1;
    fork
      begin
        while (bp_on) begin
          @(posedge clk);
          #1 o_ready = 1'($urandom_range(0, 1));
        end
        o_ready = 1'b1;
      end
      begin
        applyStimulus(15, 4'h8, 57, 32'h0800_0000);
        applyStimulus(20, 4'hE, 79, 32'h0900_0000);
        applyStimulus(2, 4'h8, 5, 32'h0A00_0000);
        applyStimulus(70, 4'hF, 280, 32'h0B00_0000);
        waitDrain();
        bp_on = 1'b0;
      end
    join
    @(posedge clk);
    #1;

    // 33 packets with gaps, so the sequence number wraps.
    for (int p = 0; p < 33; p++) begin
      applyStimulus(15, 4'h8, 57, {8'h40 + 8'(p), 24'h0});
      repeat (16) @(posedge clk);
      #1;
    end
    waitDrain();

    // Length buffer full while the output is stalled.
    o_ready = 1'b0;
    for (int p = 0; p < 17; p++) applyStimulus(1, 4'hF, 4, {8'h80 + 8'(p), 24'h0});
    @(negedge clk);
    checkOutput("ready_when_full", 64'(i_ready), 64'd0);
    @(posedge clk);
    #1 o_ready = 1'b1;
    waitDrain();

    // Reset during the 7th input word. The partial packet is lost and the sequence restarts.
    for (int i = 0; i < 6; i++) sendBeat(32'hDEAD_0000 + 32'(i), 4'hF, 1'b0, 12'd57);
    i_tdata  = 32'hDEAD_0006;
    i_tkeep  = 4'hF;
    i_tlast  = 1'b0;
    i_tvalid = 1'b1;
    #2 rst = 1'b0;
    seqm[0] = 0;
    seqm[1] = 0;
    @(negedge clk);
    checkOutput("reset_mid_outputs", 64'({o_valid, o_last, o_keep, o_data, i_ready}), 64'd0);
    i_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(15, 4'h8, 57, 32'h0C00_0000);
    waitDrain();
    k = got[0].size() - 16;
    checkOutput("seq_after_reset256", 64'(got[0][k].data), 64'hA5C0_0039);
    k = got[1].size() - 17;
    checkOutput("seq_after_reset32", 64'(got[1][k].data), 64'hA580_0020);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
